ofs_fim_eth_tx_axis_pkt_arb: RTL and testbench

- Packet-atomic round-robin arbiter that shares one AFU-side Ethernet TX AXI-S channel among NUM_PORTS requesters.
- Sits upstream of the FIM TX AXI-S-to-AVST bridge. The merged stream feeds its AXI-S slave side, so SOP derivation there stays correct.
- A grant is never interrupted mid-packet.
- Output is a registered one-entry slice.

---
 rtl/ofs_fim_eth_tx_arb_pkg.sv | 36 +++
 rtl/ofs_fim_eth_axis_reg_slice.sv | 48 ++++
 rtl/ofs_fim_eth_tx_axis_pkt_arb.sv | 125 ++++++++++++
 tb/tb_ofs_fim_eth_tx_axis_pkt_arb.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofs_fim_eth_tx_arb_pkg.sv
// Shared types and helpers for the Ethernet TX AXI-S packet arbiter.
// The OFS_FIM_ETH_TX_ARB_PKT_CNT_EN build uses PKT_CNT_W for the per-port packet counters.
package ofs_fim_eth_tx_arb_pkg;

    localparam int PKT_CNT_W = 32;
    localparam int MAX_PORTS = 8;
    localparam int MAX_IDX_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    // Unused request bits above NUM_PORTS are zero, so a modulo-8 walk gives
    // the same order as a modulo-NUM_PORTS walk for any ptr < NUM_PORTS.
    function automatic rr_pick_t rr_pick(input logic [MAX_PORTS-1:0] valid,
                                         input logic [MAX_IDX_W-1:0] ptr);
        rr_pick_t             r;
        logic [MAX_IDX_W-1:0] i;
        r = '0;
        for (int k = 0; k < MAX_PORTS; k++) begin
            i = ptr + MAX_IDX_W'(k);
            if (!r.found && valid[i]) begin
                r.found = 1'b1;
                r.idx   = i;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ofs_fim_eth_axis_reg_slice.sv
// One-entry AXI-S register stage: outputs come straight from flops and hold
// while the downstream stalls.
module ofs_fim_eth_axis_reg_slice #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic [KEEP_W-1:0] s_tkeep,
    input  logic              s_tlast,
    input  logic              s_tuser_err,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic [KEEP_W-1:0] m_tkeep,
    output logic              m_tlast,
    output logic              m_tuser_err
);

    // Space exists when empty or when the held beat leaves this cycle.
    assign s_tready = ~m_tvalid | m_tready;

    // NOTE: clocked state uses <= so every flop samples pre-edge values,
    // independent of statement order or of other always blocks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: payload flops are reset too so m_tdata/m_tkeep read zero
            // after reset, not just m_tvalid.
            m_tvalid    <= 1'b0;
            m_tdata     <= '0;
            m_tkeep     <= '0;
            m_tlast     <= 1'b0;
            m_tuser_err <= 1'b0;
        end else if (s_tvalid && s_tready) begin
            m_tvalid    <= 1'b1;
            m_tdata     <= s_tdata;
            m_tkeep     <= s_tkeep;
            m_tlast     <= s_tlast;
            m_tuser_err <= s_tuser_err;
        end else if (m_tready) begin
            m_tvalid    <= 1'b0;
        end
    end

endmodule

// File: rtl/ofs_fim_eth_tx_axis_pkt_arb.sv
// Packet-atomic round-robin arbiter merging NUM_PORTS AXI-S TX streams into one.
// Define OFS_FIM_ETH_TX_ARB_PKT_CNT_EN to add per-port packet counters (pkt_cnt, cnt_clr).
module ofs_fim_eth_tx_axis_pkt_arb
    import ofs_fim_eth_tx_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 64,
    parameter int KEEP_W    = DATA_W / 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_PORTS-1:0]           s_tvalid,
    output logic [NUM_PORTS-1:0]           s_tready,
    input  logic [NUM_PORTS*DATA_W-1:0]    s_tdata,
    input  logic [NUM_PORTS*KEEP_W-1:0]    s_tkeep,
    input  logic [NUM_PORTS-1:0]           s_tlast,
    input  logic [NUM_PORTS-1:0]           s_tuser_err,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic [DATA_W-1:0]              m_tdata,
    output logic [KEEP_W-1:0]              m_tkeep,
    output logic                           m_tlast,
    output logic                           m_tuser_err,
    output logic [$clog2(NUM_PORTS)-1:0]   grant_id,
    output logic                           busy
`ifdef OFS_FIM_ETH_TX_ARB_PKT_CNT_EN
   ,input  logic                           cnt_clr,
    output logic [NUM_PORTS*PKT_CNT_W-1:0] pkt_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    arb_state_e        state, state_next;
    logic [IDX_W-1:0]  rr_ptr, rr_ptr_next, grant_next;
    rr_pick_t          pick;

    logic              sel_valid, sel_last, sel_err;
    logic [DATA_W-1:0] sel_data;
    logic [KEEP_W-1:0] sel_keep;
    logic              slice_ready, accept;

    assign pick = rr_pick(MAX_PORTS'(s_tvalid), MAX_IDX_W'(rr_ptr));

    // Only the locked port feeds the slice, and only while BUSY.
    assign sel_valid = (state == BUSY) & s_tvalid[grant_id];
    assign sel_data  = s_tdata[grant_id*DATA_W +: DATA_W];
    assign sel_keep  = s_tkeep[grant_id*KEEP_W +: KEEP_W];
    assign sel_last  = s_tlast[grant_id];
    assign sel_err   = s_tuser_err[grant_id];
    assign accept    = sel_valid & slice_ready;
    assign busy      = (state == BUSY);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned and no latch is inferred.
        state_next  = state;
        grant_next  = grant_id;
        rr_ptr_next = rr_ptr;
        s_tready    = '0;
        case (state)
            IDLE: begin
                if (pick.found) begin
                    grant_next = IDX_W'(pick.idx);
                    state_next = BUSY;
                end
            end
            BUSY: begin
                s_tready[grant_id] = slice_ready;
                if (accept && sel_last) begin
                    state_next  = IDLE;
                    rr_ptr_next = (grant_id == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_id + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
        end else begin
            state    <= state_next;
            grant_id <= grant_next;
            rr_ptr   <= rr_ptr_next;
        end
    end

    // A reset mid-packet leaves a truncated packet downstream; nothing recovers it.
    ofs_fim_eth_axis_reg_slice #(
        .DATA_W (DATA_W),
        .KEEP_W (KEEP_W)
    ) u_out_slice (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_tvalid    (sel_valid),
        .s_tready    (slice_ready),
        .s_tdata     (sel_data),
        .s_tkeep     (sel_keep),
        .s_tlast     (sel_last),
        .s_tuser_err (sel_err),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tdata     (m_tdata),
        .m_tkeep     (m_tkeep),
        .m_tlast     (m_tlast),
        .m_tuser_err (m_tuser_err)
    );

`ifdef OFS_FIM_ETH_TX_ARB_PKT_CNT_EN
    // cnt_clr wins over an increment landing in the same cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!rst_n || cnt_clr) begin
                pkt_cnt[i*PKT_CNT_W +: PKT_CNT_W] <= '0;
            end else if (accept && sel_last && grant_id == IDX_W'(i)) begin
                pkt_cnt[i*PKT_CNT_W +: PKT_CNT_W] <= pkt_cnt[i*PKT_CNT_W +: PKT_CNT_W] + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ofs_fim_eth_tx_axis_pkt_arb.sv
// Self-checking bench for ofs_fim_eth_tx_axis_pkt_arb: directed scenarios plus random
// traffic scored against a packet-level round-robin model (counters when OFS_FIM_ETH_TX_ARB_PKT_CNT_EN).
module tb_ofs_fim_eth_tx_axis_pkt_arb;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int KW = DW / 8;

    typedef struct packed {
        logic          last;
        logic          err;
        logic [KW-1:0] keep;
        logic [DW-1:0] data;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      s_tvalid = '0;
    logic [N-1:0]      s_tready;
    logic [N*DW-1:0]   s_tdata = '0;
    logic [N*KW-1:0]   s_tkeep = '0;
    logic [N-1:0]      s_tlast = '0;
    logic [N-1:0]      s_tuser_err = '0;
    logic              m_tvalid;
    logic              m_tready = 1'b0;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic              m_tlast;
    logic              m_tuser_err;
    logic [1:0]        grant_id;
    logic              busy;
`ifdef OFS_FIM_ETH_TX_ARB_PKT_CNT_EN
    logic              cnt_clr = 1'b0;
    logic [N*32-1:0]   pkt_cnt;
`endif

    ofs_fim_eth_tx_axis_pkt_arb #(.NUM_PORTS(N), .DATA_W(DW), .KEEP_W(KW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .s_tdata     (s_tdata),
        .s_tkeep     (s_tkeep),
        .s_tlast     (s_tlast),
        .s_tuser_err (s_tuser_err),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tdata     (m_tdata),
        .m_tkeep     (m_tkeep),
        .m_tlast     (m_tlast),
        .m_tuser_err (m_tuser_err),
        .grant_id    (grant_id),
        .busy        (busy)
`ifdef OFS_FIM_ETH_TX_ARB_PKT_CNT_EN
       ,.cnt_clr     (cnt_clr),
        .pkt_cnt     (pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: per-port packet sources, expected output beats, arbitration state.
    beat_t       src_q [N][$];
    beat_t       exp_q [$];
    int          dut_grant_log [$];
    bit          m_busy = 0;
    int          m_grant = 0;
    int          m_ptr = 0;
    logic [31:0] m_cnt [N];
    int          in_cnt = 0;
    int          out_cnt = 0;

    // Stimulus knobs.
    int bubble_pct = 0;
    int rdy_pct    = 100;
    int stall_left = 0;
    int drop_port  = -1;
    bit drop_armed = 0;
    int drop_left  = 0;
    bit clr_on_tlast = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic add_pkt(input int p, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = {$urandom, $urandom};
            b.keep = (i == len - 1) ? (8'hFF >> $urandom_range(7)) : 8'hFF;
            b.err  = 1'($urandom_range(1));
            b.last = (i == len - 1);
            src_q[p].push_back(b);
        end
    endtask

    // One clock: drive at negedge, sample handshakes just before posedge, score after it.
    task automatic cycle();
        logic [N-1:0] in_x, pre_tvalid, exp_rdy;
        logic         out_x, pre_busy, pre_hold, clr;
        beat_t        pre_beat, b;
        bit           v;
        int           p;
        clr = 1'b0;
        for (int i = 0; i < N; i++) begin
            v = (src_q[i].size() != 0) && ($urandom_range(99) >= bubble_pct);
            if (i == drop_port && drop_left > 0) v = 0;
            b = (src_q[i].size() != 0) ? src_q[i][0] : '0;
            s_tvalid[i]            = v;
            s_tdata[i*DW +: DW]    = b.data;
            s_tkeep[i*KW +: KW]    = b.keep;
            s_tlast[i]             = b.last;
            s_tuser_err[i]         = b.err;
        end
        if (drop_left > 0) drop_left--;
        if (stall_left > 0) begin
            m_tready = 1'b0;
            stall_left--;
        end else begin
            m_tready = ($urandom_range(99) < rdy_pct);
        end
`ifdef OFS_FIM_ETH_TX_ARB_PKT_CNT_EN
        cnt_clr = 1'b0;
`endif
        #1;
        exp_rdy = '0;
        if (m_busy && (!m_tvalid || m_tready)) exp_rdy[m_grant] = 1'b1;
        check("s_tready", s_tready, exp_rdy);
        in_x = s_tvalid & s_tready;
`ifdef OFS_FIM_ETH_TX_ARB_PKT_CNT_EN
        if (clr_on_tlast && m_busy && in_x[m_grant] && src_q[m_grant][0].last) begin
            cnt_clr      = 1'b1;
            clr          = 1'b1;
            clr_on_tlast = 0;
        end
`endif
        out_x      = m_tvalid & m_tready;
        pre_tvalid = s_tvalid;
        pre_busy   = busy;
        pre_hold   = m_tvalid & ~m_tready;
        pre_beat   = {m_tlast, m_tuser_err, m_tkeep, m_tdata};

        @(posedge clk);
        #1;
        if (out_x) begin
            out_cnt++;
            if (exp_q.size() == 0) check("spurious_out", 1, 0);
            else check("out_beat", pre_beat, exp_q.pop_front());
        end
        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                p = (m_ptr + k) % N;
                if (!m_busy && pre_tvalid[p]) begin
                    m_busy  = 1;
                    m_grant = p;
                end
            end
        end else if (in_x[m_grant]) begin
            in_cnt++;
            b = src_q[m_grant].pop_front();
            exp_q.push_back(b);
            if (drop_armed && m_grant == drop_port) begin
                drop_armed = 0;
                drop_left  = 3;
            end
            if (b.last) begin
                m_busy = 0;
                m_ptr  = (m_grant + 1) % N;
                m_cnt[m_grant]++;
            end
        end
        if (clr) for (int i = 0; i < N; i++) m_cnt[i] = '0;
        if (busy && !pre_busy) dut_grant_log.push_back(int'(grant_id));
        if (pre_hold) check("hold", {m_tvalid, m_tlast, m_tuser_err, m_tkeep, m_tdata}, {1'b1, pre_beat});
        check("busy", busy, m_busy);
        check("grant_id", grant_id, m_grant);
        check("m_tvalid", m_tvalid, exp_q.size() != 0);
`ifdef OFS_FIM_ETH_TX_ARB_PKT_CNT_EN
        for (int i = 0; i < N; i++) check("pkt_cnt", pkt_cnt[i*32 +: 32], m_cnt[i]);
`endif
        @(negedge clk);
    endtask

    task automatic do_reset(input int ncyc);
        rst_n    = 1'b0;
        m_tready = 1'b1;
        repeat (ncyc) begin
            @(posedge clk);
            #1;
            check("rst_m_tvalid", m_tvalid, 0);
            check("rst_busy", busy, 0);
            check("rst_grant_id", grant_id, 0);
            check("rst_s_tready", s_tready, 0);
            check("rst_m_payload", {m_tlast, m_tuser_err, m_tkeep, m_tdata}, 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            m_cnt[i] = '0;
        end
        exp_q.delete();
        dut_grant_log.delete();
        m_busy = 0; m_grant = 0; m_ptr = 0;
        stall_left = 0; drop_port = -1; drop_armed = 0; drop_left = 0; clr_on_tlast = 0;
        @(negedge clk);
    endtask

    function automatic bit all_drained();
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 0;
        return (exp_q.size() == 0) && !m_busy;
    endfunction

    task automatic run_until_idle(input int budget);
        int n = 0;
        while (!all_drained() && n < budget) begin
            cycle();
            n++;
        end
        check("drain_timeout", all_drained(), 1);
    endtask

    task automatic wait_in(input int target, input int budget);
        int n = 0;
        while (in_cnt < target && n < budget) begin
            cycle();
            n++;
        end
        check("wait_in_timeout", in_cnt >= target, 1);
    endtask

    task automatic wait_out(input int target, input int budget);
        int n = 0;
        while (out_cnt < target && n < budget) begin
            cycle();
            n++;
        end
        check("wait_out_timeout", out_cnt >= target, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) m_cnt[i] = '0;
        do_reset(2);

        // Single requester: port 2, 3 beats, downstream always ready.
        bubble_pct = 0; rdy_pct = 100;
        add_pkt(2, 3);
        run_until_idle(50);
        check("single_grant_cnt", dut_grant_log.size(), 1);
        if (dut_grant_log.size() >= 1) check("single_grant", dut_grant_log[0], 2);
        // rr_ptr should now be 3: with 0 and 3 both requesting, 3 wins.
        add_pkt(0, 1);
        add_pkt(3, 1);
        run_until_idle(50);
        check("after2_cnt", dut_grant_log.size(), 3);
        if (dut_grant_log.size() >= 3) begin
            check("after2_first", dut_grant_log[1], 3);
            check("after2_second", dut_grant_log[2], 0);
        end

        // All ports continuously valid with 1-beat packets.
        do_reset(1);
        for (int i = 0; i < N; i++) begin
            add_pkt(i, 1);
            add_pkt(i, 1);
        end
        run_until_idle(100);
        check("rr_log_cnt", dut_grant_log.size(), 8);
        if (dut_grant_log.size() >= 5) begin
            check("rr_g0", dut_grant_log[0], 0);
            check("rr_g1", dut_grant_log[1], 1);
            check("rr_g2", dut_grant_log[2], 2);
            check("rr_g3", dut_grant_log[3], 3);
            check("rr_g4", dut_grant_log[4], 0);
        end

        // Backpressure: 4-beat packet, m_tready low for 5 cycles on beat 2.
        do_reset(1);
        add_pkt(0, 4);
        wait_out(out_cnt + 1, 20);
        stall_left = 5;
        run_until_idle(50);

        // Port 1 drops tvalid for 3 cycles mid-packet while port 0 waits.
        do_reset(1);
        add_pkt(1, 4);
        cycle();
        add_pkt(0, 2);
        drop_port = 1; drop_armed = 1;
        run_until_idle(60);
        check("drop_log_cnt", dut_grant_log.size(), 2);
        if (dut_grant_log.size() >= 2) begin
            check("drop_g0", dut_grant_log[0], 1);
            check("drop_g1", dut_grant_log[1], 0);
        end

        // Reset during beat 2 of a packet, then first grant goes to the lowest valid port.
        do_reset(1);
        add_pkt(3, 1);
        run_until_idle(20);
        add_pkt(2, 4);
        wait_in(in_cnt + 1, 20);
        do_reset(1);
        add_pkt(1, 2);
        add_pkt(3, 2);
        run_until_idle(50);
        check("post_rst_cnt", dut_grant_log.size(), 2);
        if (dut_grant_log.size() >= 1) check("post_rst_first", dut_grant_log[0], 1);

`ifdef OFS_FIM_ETH_TX_ARB_PKT_CNT_EN
        // 5 packets on port 3, then clear in the same cycle as a 6th tlast.
        do_reset(1);
        for (int k = 0; k < 5; k++) add_pkt(3, 2);
        run_until_idle(100);
        check("cnt3_five", pkt_cnt[3*32 +: 32], 5);
        add_pkt(3, 2);
        clr_on_tlast = 1;
        run_until_idle(30);
        check("cnt3_clr", pkt_cnt[3*32 +: 32], 0);
`endif

        // Random traffic with bubbles and backpressure.
        do_reset(1);
        bubble_pct = 25; rdy_pct = 70;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(3) == 0) begin
                int p = $urandom_range(N - 1);
                if (src_q[p].size() < 12) add_pkt(p, $urandom_range(1, 5));
            end
            cycle();
        end
        bubble_pct = 0; rdy_pct = 100;
        run_until_idle(2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
